pattern_seq_gen: RTL and testbench
==================================

Name: pattern_seq_gen

Overview:
Parametrised successor of the BCD-counter/pattern-ROM/bit-mux chain. A modulo-MOD up/down counter addresses a writable DEPTH x DATA_W pattern memory. A bit-select stage then emits one serial bit per step, taken from the addressed word at the bit position given by the count. The block sits between the clock source and downstream serial-pattern consumers. It replaces fixed-BCD, fixed-ROM sequence generators.

Parameters:
DATA_W, 16, pattern word width in bits
DEPTH, 16, pattern memory depth in words
MOD, 10, counter modulus; legal range 2..min(DEPTH, DATA_W), enforced by elaboration-time check
CNT_W, $clog2(DEPTH), counter and address width (derived)

Ports:
clk  in  1  clock, all state changes on rising edge
rst  in  1  synchronous, active-high reset
en  in  1  count enable
dir  in  1  direction: 1 = up, 0 = down
load  in  1  synchronous load of load_val into count
load_val  in  CNT_W  load value; values >= MOD are clamped to MOD-1
wr_en  in  1  pattern memory write strobe
wr_addr  in  CNT_W  write address; addresses >= DEPTH are ignored
wr_data  in  DATA_W  write data
count  out  CNT_W  current count (registered)
data  out  DATA_W  mem[count], combinational read
out  out  1  data[count], combinational
wrap  out  1  one-cycle pulse on terminal-count wrap

Behaviour:
- Reset (rst=1 at edge): count=0, wrap=0; mem[i] = 1 << (i mod DATA_W) for all i. Resulting outputs: data=16'h0001, out=1.
- Priority per edge: rst > load > en. load ignores en.
- Count, up (dir=1, en=1): count+1. From MOD-1, count goes to 0 and wrap=1 for that following cycle.
- Count, down (dir=0, en=1): count-1. From 0, count goes to MOD-1 and wrap=1.
- wrap is registered and is 0 in every other cycle, including load cycles.
- en=0: count holds and wrap=0.
- load with en=1 in the same cycle: the loaded value wins and no step occurs.
- Memory write: synchronous on the edge. The written word is visible on data from the next cycle, including when wr_addr==count. A write in the same edge as rst is discarded.
- Read path: data and out are pure functions of count and memory contents, with zero added latency.
- Bit index for out equals count. MOD <= DATA_W guarantees the index is in range.
- Reset mid-sequence: the next cycle shows count=0 with the default pattern restored.

Optional Feature:
SEQ_ONESHOT_EN
- Defined: the counter saturates at the terminal value (MOD-1 when counting up, 0 when counting down) instead of wrapping. wrap becomes sticky "done": it sets on arrival at the terminal value and clears only on rst or load. A direction reversal while at the terminal value leaves it and clears done on the next step.
- Undefined: wrap-around behaviour as above. Port list is identical in both builds.

Decomposition:
- Shared package (pattern_seq_pkg): CNT_W derivation function, the default-pattern function (1 << (i mod DATA_W)), direction encodings UP=1'b1 and DN=1'b0.
- One natural sub-module: seq_counter, holding the modulo up/down/load counter and wrap/done logic. Memory and bit-select stay in the top.

Test Plan:
1. Reset, then en=1, dir=1, MOD=10 for 12 cycles -> count 0..9,0,1. wrap high only in the cycle count=0 after 9. out=1 at every step (default pattern).
2. Reset, en=1, dir=0 -> count 0,9,8. wrap pulses on the 9.
3. Write wr_addr=3 with wr_data=16'h0000, then step to count=3 -> data=16'h0000, out=0. Write wr_addr=3 with 16'h0008 while count=3 -> next cycle out=1.
4. load=1, load_val=12, en=1 -> count=9 next cycle with no step. Then load_val=5 with rst=1 -> count=0.
5. rst asserted at count=7 with mem[2] overwritten -> count=0, mem[2]=16'h0004 restored, wrap=0.
6. With SEQ_ONESHOT_EN defined: up-count from 0 -> holds at 9, wrap stays 1 until load_val=0 is applied, then wrap=0.

Source files
------------

// File: rtl/pattern_seq_pkg.sv
// Shared helpers for the pattern sequence generator: counter width derivation,
// default pattern bit placement and direction encodings.
package pattern_seq_pkg;

  typedef enum logic {
    DN = 1'b0,
    UP = 1'b1
  } dir_e;

  function automatic int unsigned cnt_w_of(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Bit set in default word i: the pattern is 1 << (i mod data_w).
  function automatic int unsigned default_bit_pos(input int unsigned i,
                                                  input int unsigned data_w);
    return i % data_w;
  endfunction

endpackage

// File: rtl/pattern_seq_gen_counter.sv
// Modulo-MOD up/down/load counter with wrap pulse.
// Build option SEQ_ONESHOT_EN: saturate at the terminal value with a sticky done flag.
module seq_counter
  import pattern_seq_pkg::*;
#(
  parameter int unsigned MOD   = 10,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MOD - 1);

  logic [CNT_W-1:0] count_nxt;
  logic             wrap_nxt;
  logic [CNT_W-1:0] load_clamped;
  logic             going_up;

  assign load_clamped = (load_val > LAST) ? LAST : load_val;
  assign going_up     = (dir_e'(dir) == UP);

  always_comb begin
    count_nxt = count;
    wrap_nxt  = 1'b0;
    if (load) begin
      count_nxt = load_clamped;
    end else if (en) begin
`ifdef SEQ_ONESHOT_EN
      // Done sets when a step lands on the terminal value and holds while parked;
      // stepping away (direction reversal) recomputes it as clear.
      if (going_up) begin
        if (count == LAST) begin
          wrap_nxt = wrap;
        end else begin
          count_nxt = count + 1'b1;
          wrap_nxt  = (count_nxt == LAST);
        end
      end else begin
        if (count == '0) begin
          wrap_nxt = wrap;
        end else begin
          count_nxt = count - 1'b1;
          wrap_nxt  = (count_nxt == '0);
        end
      end
`else
      if (going_up) begin
        if (count == LAST) begin
          count_nxt = '0;
          wrap_nxt  = 1'b1;
        end else begin
          count_nxt = count + 1'b1;
        end
      end else begin
        if (count == '0) begin
          count_nxt = LAST;
          wrap_nxt  = 1'b1;
        end else begin
          count_nxt = count - 1'b1;
        end
      end
`endif
    end else begin
`ifdef SEQ_ONESHOT_EN
      wrap_nxt = wrap;
`else
      wrap_nxt = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= count_nxt;
      wrap  <= wrap_nxt;
    end
  end

endmodule

// File: rtl/pattern_seq_gen.sv
// Counter-addressed writable pattern memory with per-step serial bit select.
// Build option SEQ_ONESHOT_EN selects saturating one-shot counting (see seq_counter).
module pattern_seq_gen
  import pattern_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned MOD    = 10,
  parameter int unsigned CNT_W  = cnt_w_of(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              dir,
  input  logic              load,
  input  logic [CNT_W-1:0]  load_val,
  input  logic              wr_en,
  input  logic [CNT_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] data,
  output logic              out,
  output logic              wrap
);

  if (MOD < 2 || MOD > DEPTH || MOD > DATA_W) begin : g_bad_mod
    $error("pattern_seq_gen: MOD must lie in 2..min(DEPTH, DATA_W)");
  end

  function automatic logic [DATA_W-1:0] default_word(input int unsigned i);
    return DATA_W'(1) << default_bit_pos(i, DATA_W);
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  seq_counter #(
    .MOD   (MOD),
    .CNT_W (CNT_W)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .wrap     (wrap)
  );

  // One register per word; addresses with no matching word (>= DEPTH) write nothing.
  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_word
    localparam logic [CNT_W-1:0] ADDR = CNT_W'(g);
    logic [DATA_W-1:0] word;

    always_ff @(posedge clk) begin
      if (rst) begin
        word <= default_word(g);
      end else if (wr_en && wr_addr == ADDR) begin
        word <= wr_data;
      end
    end

    assign mem[g] = word;
  end

  assign data = mem[count];
  assign out  = data[count];

endmodule

// File: tb/tb_pattern_seq_gen.sv
// Directed table-driven bench for pattern_seq_gen (DATA_W=16, DEPTH=16, MOD=10).
module tb_pattern_seq_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        dir = 1'b1;
  logic        load = 1'b0;
  logic [3:0]  load_val = '0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [3:0]  count;
  logic [15:0] data;
  logic        out;
  logic        wrap;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic        en;
    logic        dir;
    logic        load;
    logic [3:0]  load_val;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [3:0]  exp_count;
    logic        exp_wrap;
    logic [15:0] exp_data;
    logic        exp_out;
  } vec_t;

  vec_t vecs[$];

  pattern_seq_gen #(
    .DATA_W (16),
    .DEPTH  (16),
    .MOD    (10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .count    (count),
    .data     (data),
    .out      (out),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic e, input logic d, input logic l,
                     input logic [3:0] lv, input logic w, input logic [3:0] wa,
                     input logic [15:0] wd, input logic [3:0] ec, input logic ew,
                     input logic [15:0] ed, input logic eo);
    vec_t v;
    v.rst = r; v.en = e; v.dir = d; v.load = l; v.load_val = lv;
    v.wr_en = w; v.wr_addr = wa; v.wr_data = wd;
    v.exp_count = ec; v.exp_wrap = ew; v.exp_data = ed; v.exp_out = eo;
    vecs.push_back(v);
  endtask

  task automatic apply_and_check(input vec_t v, input int idx);
    rst = v.rst; en = v.en; dir = v.dir; load = v.load; load_val = v.load_val;
    wr_en = v.wr_en; wr_addr = v.wr_addr; wr_data = v.wr_data;
    @(posedge clk);
    #1;
    chk($sformatf("v%0d count", idx), 32'(count), 32'(v.exp_count));
    chk($sformatf("v%0d wrap", idx), 32'(wrap), 32'(v.exp_wrap));
    chk($sformatf("v%0d data", idx), 32'(data), 32'(v.exp_data));
    chk($sformatf("v%0d out", idx), 32'(out), 32'(v.exp_out));
  endtask

  initial begin
    // rst en dir load lv wr wa wd | count wrap data out
    add(1, 0, 1, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0001, 1);
`ifndef SEQ_ONESHOT_EN
    // up count through the wrap
    for (int i = 1; i <= 9; i++)
      add(0, 1, 1, 0, 0, 0, 0, 16'h0000, 4'(i), 0, 16'h0001 << i, 1);
    add(0, 1, 1, 0, 0, 0, 0, 16'h0000, 0, 1, 16'h0001, 1);
    add(0, 1, 1, 0, 0, 0, 0, 16'h0000, 1, 0, 16'h0002, 1);
    add(0, 0, 1, 0, 0, 0, 0, 16'h0000, 1, 0, 16'h0002, 1);  // hold
    // down count from 0
    add(1, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0001, 1);
    add(0, 1, 0, 0, 0, 0, 0, 16'h0000, 9, 1, 16'h0200, 1);
    add(0, 1, 0, 0, 0, 0, 0, 16'h0000, 8, 0, 16'h0100, 1);
    // memory writes
    add(1, 0, 1, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0001, 1);
    add(0, 0, 1, 0, 0, 1, 3, 16'h0000, 0, 0, 16'h0001, 1);
    add(0, 1, 1, 0, 0, 0, 0, 16'h0000, 1, 0, 16'h0002, 1);
    add(0, 1, 1, 0, 0, 0, 0, 16'h0000, 2, 0, 16'h0004, 1);
    add(0, 1, 1, 0, 0, 0, 0, 16'h0000, 3, 0, 16'h0000, 0);
    add(0, 0, 1, 0, 0, 1, 3, 16'h0010, 3, 0, 16'h0010, 0);
    add(0, 0, 1, 0, 0, 1, 3, 16'h0008, 3, 0, 16'h0008, 1);
    // load clamp, load beats en, load cycle keeps wrap low
    add(0, 1, 1, 1, 12, 0, 0, 16'h0000, 9, 0, 16'h0200, 1);
    add(0, 1, 1, 1, 9, 0, 0, 16'h0000, 9, 0, 16'h0200, 1);
    add(0, 1, 1, 0, 0, 0, 0, 16'h0000, 0, 1, 16'h0001, 1);
    add(0, 1, 0, 1, 4, 0, 0, 16'h0000, 4, 0, 16'h0010, 1);
    add(1, 0, 1, 1, 5, 0, 0, 16'h0000, 0, 0, 16'h0001, 1);
    // reset mid-sequence restores overwritten word; write with rst is dropped
    add(0, 0, 1, 0, 0, 1, 2, 16'hFFFF, 0, 0, 16'h0001, 1);
    add(0, 0, 1, 1, 2, 0, 0, 16'h0000, 2, 0, 16'hFFFF, 1);
    add(0, 0, 1, 1, 7, 0, 0, 16'h0000, 7, 0, 16'h0080, 1);
    add(1, 1, 1, 0, 0, 1, 2, 16'h1234, 0, 0, 16'h0001, 1);
    add(0, 0, 1, 1, 2, 0, 0, 16'h0000, 2, 0, 16'h0004, 1);
`else
    // one-shot: saturate at 9 with sticky done until load
    for (int i = 1; i <= 8; i++)
      add(0, 1, 1, 0, 0, 0, 0, 16'h0000, 4'(i), 0, 16'h0001 << i, 1);
    add(0, 1, 1, 0, 0, 0, 0, 16'h0000, 9, 1, 16'h0200, 1);
    add(0, 1, 1, 0, 0, 0, 0, 16'h0000, 9, 1, 16'h0200, 1);
    add(0, 0, 1, 0, 0, 0, 0, 16'h0000, 9, 1, 16'h0200, 1);
    add(0, 1, 0, 0, 0, 0, 0, 16'h0000, 8, 0, 16'h0100, 1);
    add(0, 1, 1, 0, 0, 0, 0, 16'h0000, 9, 1, 16'h0200, 1);
    add(0, 1, 1, 1, 0, 0, 0, 16'h0000, 0, 0, 16'h0001, 1);
    add(0, 1, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0001, 1);
`endif

    @(negedge clk);
    foreach (vecs[i]) apply_and_check(vecs[i], i);

    // hand sequence: write on the addressed word at the same edge as a step
    rst = 1; en = 0; load = 0; wr_en = 0;
    @(posedge clk); #1;
    rst = 0; load = 1; load_val = 4; en = 0;
    @(posedge clk); #1;
    load = 0; wr_en = 1; wr_addr = 4; wr_data = 16'h0000;
    @(posedge clk); #1;
    chk("wr_same_count data", 32'(data), 32'h0000);
    chk("wr_same_count out", 32'(out), 32'(0));
    wr_en = 1; wr_addr = 5; wr_data = 16'h0000; en = 1; dir = 1;
    @(posedge clk); #1;
    chk("wr_and_step count", 32'(count), 32'(5));
    chk("wr_and_step data", 32'(data), 32'h0000);
    wr_en = 0; en = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
